// File: rtl/pwm_pkg.sv
// pwm_pkg -- shared state encoding, default widths and the clamped duty step helper.
// Rev 1.0
`default_nettype none

package pwm_pkg;

    localparam int DEF_CBITS        = 20;
    localparam int DEF_DBITS        = 8;
    localparam int DEF_STEP_PERIODS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Wide arithmetic so neither the add nor the subtract can wrap; result never passes goal.
    function automatic logic [31:0] sat_step(input logic [31:0] cur,
                                             input logic [31:0] goal,
                                             input logic [31:0] step);
        logic [31:0] nxt;
        nxt = cur;
        if (cur < goal) begin
            nxt = ((goal - cur) > step) ? (cur + step) : goal;
        end else if (cur > goal) begin
            nxt = ((cur - goal) > step) ? (cur - step) : goal;
        end
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_core.sv
// pwm_core -- free-running period counter, duty latch at wrap and registered compare.
// Rev 1.0
`default_nettype none

module pwm_core
    import pwm_pkg::*;
#(
    parameter int CBITS = DEF_CBITS,
    parameter int DBITS = DEF_DBITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DBITS-1:0] duty_nxt_i,
    output logic             pwm_o,
    output logic [DBITS-1:0] duty_act_o,
    output logic             period_tick_o
);

    logic [CBITS-1:0] cnt_q;
    logic [DBITS-1:0] duty_act_q;
    logic             pwm_q;
    logic             w_tick;

    assign w_tick = &cnt_q;

    // duty_act only moves on the wrap edge so a pulse in flight is never cut short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            cnt_q <= cnt_q + CBITS'(1);
            pwm_q <= (cnt_q[CBITS-1 -: DBITS] < duty_act_q);
            if (w_tick) begin
                duty_act_q <= duty_nxt_i;
            end
        end
    end

    assign pwm_o         = pwm_q;
    assign duty_act_o    = duty_act_q;
    assign period_tick_o = w_tick;

endmodule

`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl -- fade sequencer: FSM and step timer around pwm_core.
// Rev 1.0 -- optional auto-breathing built when PWM_BREATHE_EN is defined.
`default_nettype none

module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int CBITS        = DEF_CBITS,
    parameter int DBITS        = DEF_DBITS,
    parameter int STEP_PERIODS = DEF_STEP_PERIODS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [DBITS-1:0] target_duty,
    input  logic [DBITS-1:0] step_size,
    output logic             pwm_out,
    output logic [DBITS-1:0] duty_act,
    output logic             period_tick,
    output logic             busy,
    output logic             done
);

    localparam int             SCW       = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [SCW-1:0] STEP_LAST = SCW'(STEP_PERIODS - 1);

    state_e           state_q, state_d;
    logic [DBITS-1:0] goal_q, goal_d;
    logic [DBITS-1:0] step_q, step_d;
    logic [DBITS-1:0] duty_cur_q, duty_cur_d;
    logic [SCW-1:0]   step_cnt_q, step_cnt_d;
    logic             done_q, done_d;
`ifdef PWM_BREATHE_EN
    logic [DBITS-1:0] tgt_q, tgt_d;
    logic             idle_req_q, idle_req_d;
`endif

    logic             w_tick;
    logic             w_busy;
    logic             w_cmd;
    logic             w_timer_en;
    logic             w_period_done;
    logic [DBITS-1:0] w_step_len;

    pwm_core #(
        .CBITS (CBITS),
        .DBITS (DBITS)
    ) u_core (
        .clk           (clk),
        .rst           (rst),
        .duty_nxt_i    (duty_cur_q),
        .pwm_o         (pwm_out),
        .duty_act_o    (duty_act),
        .period_tick_o (w_tick)
    );

    assign w_busy     = (state_q == ST_RAMP) || (state_q == ST_DRAIN);
    assign w_step_len = (step_size == '0) ? DBITS'(1) : step_size;
`ifdef PWM_BREATHE_EN
    assign w_timer_en = w_busy || ((state_q == ST_HOLD) && (goal_q != '0));
`else
    assign w_timer_en = w_busy;
`endif
    assign w_period_done = w_tick && (step_cnt_q == STEP_LAST);

    always_comb begin
        state_d    = state_q;
        goal_d     = goal_q;
        step_d     = step_q;
        duty_cur_d = duty_cur_q;
        step_cnt_d = step_cnt_q;
        done_d     = 1'b0;
        w_cmd      = 1'b0;
`ifdef PWM_BREATHE_EN
        tgt_d      = tgt_q;
        idle_req_d = idle_req_q;
`endif

        if (stop && (state_q != ST_IDLE)) begin
            goal_d  = '0;
            state_d = ST_DRAIN;
            w_cmd   = 1'b1;
`ifdef PWM_BREATHE_EN
            idle_req_d = 1'b1;
`endif
        end else if (start) begin
            goal_d  = target_duty;
            step_d  = w_step_len;
            state_d = ST_RAMP;
            w_cmd   = 1'b1;
`ifdef PWM_BREATHE_EN
            tgt_d      = target_duty;
            idle_req_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_RAMP: begin
                    if (duty_cur_q == goal_q) begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (duty_cur_q == '0) begin
                        done_d = 1'b1;
`ifdef PWM_BREATHE_EN
                        if (!idle_req_q && (tgt_q != '0)) begin
                            state_d = ST_RAMP;
                            goal_d  = tgt_q;
                        end else begin
                            state_d = ST_IDLE;
                        end
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
`ifdef PWM_BREATHE_EN
                ST_HOLD: begin
                    if ((goal_q != '0) && w_period_done) begin
                        state_d = ST_DRAIN;
                        goal_d  = '0;
                    end
                end
`endif
                default: ;
            endcase
        end

        // Any accepted command or state change restarts the period count.
        if (w_cmd || (state_d != state_q)) begin
            step_cnt_d = '0;
        end else if (w_timer_en && w_tick) begin
            if (step_cnt_q == STEP_LAST) begin
                step_cnt_d = '0;
                if (w_busy) begin
                    duty_cur_d = DBITS'(sat_step(32'(duty_cur_q), 32'(goal_q), 32'(step_q)));
                end
            end else begin
                step_cnt_d = step_cnt_q + SCW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            goal_q     <= '0;
            step_q     <= '0;
            duty_cur_q <= '0;
            step_cnt_q <= '0;
            done_q     <= 1'b0;
`ifdef PWM_BREATHE_EN
            tgt_q      <= '0;
            idle_req_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            goal_q     <= goal_d;
            step_q     <= step_d;
            duty_cur_q <= duty_cur_d;
            step_cnt_q <= step_cnt_d;
            done_q     <= done_d;
`ifdef PWM_BREATHE_EN
            tgt_q      <= tgt_d;
            idle_req_q <= idle_req_d;
`endif
        end
    end

    assign period_tick = w_tick;
    assign busy        = w_busy;
    assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl -- randomized and directed checks against a behavioural fade model.
// Rev 1.0
`default_nettype none

module tb_pwm_ramp_ctrl;

    localparam int CB = 6;
    localparam int DB = 3;
    localparam int SP = 2;
    localparam int CMAX = (1 << CB) - 1;
    localparam int LSB_CYC = 1 << (CB - DB);

    localparam int M_IDLE  = 0;
    localparam int M_RAMP  = 1;
    localparam int M_HOLD  = 2;
    localparam int M_DRAIN = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [DB-1:0] target_duty = '0;
    logic [DB-1:0] step_size = '0;
    logic          pwm_out;
    logic [DB-1:0] duty_act;
    logic          period_tick;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(
        .CBITS        (CB),
        .DBITS        (DB),
        .STEP_PERIODS (SP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .target_duty (target_duty),
        .step_size   (step_size),
        .pwm_out     (pwm_out),
        .duty_act    (duty_act),
        .period_tick (period_tick),
        .busy        (busy),
        .done        (done)
    );

    // Behavioural model: cycle counter, duty values and a coarse mode as plain integers.
    int m_cnt, m_act, m_pwm, m_duty, m_goal, m_step, m_mode, m_periods, m_done, m_tgt, m_flag;
    bit m_breathe;

    initial begin
`ifdef PWM_BREATHE_EN
        m_breathe = 1'b1;
`else
        m_breathe = 1'b0;
`endif
    end

    function automatic int toward(input int cur, input int goal, input int stp);
        if (cur < goal) return (cur + stp > goal) ? goal : cur + stp;
        if (cur > goal) return (cur - stp < goal) ? goal : cur - stp;
        return cur;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_act = 0; m_pwm = 0; m_duty = 0; m_goal = 0; m_step = 0;
            m_mode = M_IDLE; m_periods = 0; m_done = 0; m_tgt = 0; m_flag = 0;
        end else begin
            bit wrap;
            wrap   = (m_cnt == CMAX);
            m_pwm  = ((m_cnt / LSB_CYC) < m_act) ? 1 : 0;
            if (wrap) m_act = m_duty;
            m_cnt  = (m_cnt + 1) % (CMAX + 1);
            m_done = 0;
            if (stop && m_mode != M_IDLE) begin
                m_goal = 0; m_mode = M_DRAIN; m_periods = 0; m_flag = 1;
            end else if (start) begin
                m_goal = target_duty; m_tgt = target_duty;
                m_step = (step_size == 0) ? 1 : int'(step_size);
                m_mode = M_RAMP; m_periods = 0; m_flag = 0;
            end else if (m_mode == M_RAMP && m_duty == m_goal) begin
                m_mode = M_HOLD; m_done = 1; m_periods = 0;
            end else if (m_mode == M_DRAIN && m_duty == 0) begin
                m_done = 1; m_periods = 0;
                if (m_breathe && !m_flag && m_tgt != 0) begin
                    m_mode = M_RAMP; m_goal = m_tgt;
                end else begin
                    m_mode = M_IDLE;
                end
            end else if (m_mode == M_HOLD && m_breathe && m_goal != 0) begin
                if (wrap) m_periods++;
                if (m_periods == SP) begin
                    m_mode = M_DRAIN; m_goal = 0; m_periods = 0;
                end
            end else if (m_mode == M_RAMP || m_mode == M_DRAIN) begin
                if (wrap) m_periods++;
                if (m_periods == SP) begin
                    m_periods = 0;
                    m_duty = toward(m_duty, m_goal, m_step);
                end
            end
        end
    end

    logic [6:0] dut_vec;
    assign dut_vec = {pwm_out, duty_act, period_tick, busy, done};

    function automatic logic [6:0] model_vec();
        logic b;
        b = (m_mode == M_RAMP || m_mode == M_DRAIN);
        return {1'(m_pwm), 3'(m_act), (m_cnt == CMAX), b, 1'(m_done)};
    endfunction

    // Observation window statistics (no pass/fail judgement here).
    int            obs_mism, obs_dones, obs_badact, obs_hi;
    logic [6:0]    obs_got, obs_exp;
    logic [DB-1:0] obs_seen[$];

    task automatic run_obs(input int n);
        logic [DB-1:0] pa;
        logic          pt;
        obs_mism = 0; obs_dones = 0; obs_badact = 0; obs_hi = 0;
        obs_got = '0; obs_exp = '0;
        obs_seen.delete();
        pa = duty_act;
        pt = period_tick;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            if (dut_vec !== model_vec()) begin
                if (obs_mism == 0) begin obs_got = dut_vec; obs_exp = model_vec(); end
                obs_mism++;
            end
            if (duty_act !== pa) begin
                obs_seen.push_back(duty_act);
                if (pt !== 1'b1) obs_badact++;
            end
            if (done === 1'b1) obs_dones++;
            if (c >= n - (CMAX + 1) && pwm_out === 1'b1) obs_hi++;
            pa = duty_act;
            pt = period_tick;
        end
    endtask

    function automatic string seen_str();
        string s;
        s = "";
        foreach (obs_seen[i]) s = {s, $sformatf("%0d ", obs_seen[i])};
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_tests++;
        if ({pwm_out, duty_act, period_tick, busy, done} !== 7'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %b required 0000000", dut_vec);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run_obs(200);
        n_tests++;
        if (obs_mism != 0) begin
            n_fail++; $display("FAIL idle_model: %0d cycles differ, first got %b required %b", obs_mism, obs_got, obs_exp);
        end
        n_tests++;
        if (obs_dones != 0 || obs_hi != 0 || busy !== 1'b0 || duty_act !== '0) begin
            n_fail++; $display("FAIL idle_quiet: done count %0d pwm high %0d busy %b duty_act %0d, required 0 0 0 0",
                               obs_dones, obs_hi, busy, duty_act);
        end
    endtask

    task automatic test_ramp_up();
        target_duty = 3'd6; step_size = 3'd2; start = 1'b1;
        run_obs(700);
        n_tests++;
        if (obs_mism != 0) begin
            n_fail++; $display("FAIL ramp_model: %0d cycles differ, first got %b required %b", obs_mism, obs_got, obs_exp);
        end
        n_tests++;
        if (obs_seen.size() != 3 || obs_seen[0] != 3'd2 || obs_seen[1] != 3'd4 || obs_seen[2] != 3'd6) begin
            n_fail++; $display("FAIL ramp_steps: got %s required 2 4 6", seen_str());
        end
        n_tests++;
        if (obs_dones != 1) begin
            n_fail++; $display("FAIL ramp_done: got %0d pulses required 1", obs_dones);
        end
        n_tests++;
        if (obs_badact != 0) begin
            n_fail++; $display("FAIL ramp_act_timing: got %0d off-wrap changes required 0", obs_badact);
        end
        n_tests++;
        if (obs_hi != 48) begin
            n_fail++; $display("FAIL ramp_high_time: got %0d required 48", obs_hi);
        end
    endtask

    task automatic test_clamp_drain();
        stop = 1'b1;
        run_obs(600);
        n_tests++;
        if (obs_mism != 0 || busy !== 1'b0 || duty_act !== '0) begin
            n_fail++; $display("FAIL predrain: mismatches %0d busy %b duty_act %0d required 0 0 0", obs_mism, busy, duty_act);
        end
        target_duty = 3'd7; step_size = 3'd3; start = 1'b1;
        run_obs(700);
        n_tests++;
        if (obs_mism != 0 || obs_seen.size() != 3 || obs_seen[0] != 3'd3 || obs_seen[1] != 3'd6 || obs_seen[2] != 3'd7) begin
            n_fail++; $display("FAIL clamp_steps: got %s (mismatches %0d) required 3 6 7", seen_str(), obs_mism);
        end
        stop = 1'b1;
        run_obs(700);
        n_tests++;
        if (obs_mism != 0 || obs_seen.size() != 3 || obs_seen[0] != 3'd4 || obs_seen[1] != 3'd1 || obs_seen[2] != 3'd0) begin
            n_fail++; $display("FAIL drain_steps: got %s (mismatches %0d) required 4 1 0", seen_str(), obs_mism);
        end
        n_tests++;
        if (obs_dones != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL drain_idle: done count %0d busy %b required 1 0", obs_dones, busy);
        end
    endtask

    task automatic test_reverse();
        int pre_mism;
        int k;
        pre_mism = 0;
        target_duty = 3'd6; step_size = 3'd2; start = 1'b1;
        for (k = 0; k < 1000 && m_duty != 4; k++) begin
            run_obs(1);
            pre_mism += obs_mism;
        end
        n_tests++;
        if (k >= 1000 || pre_mism != 0) begin
            n_fail++; $display("FAIL reverse_reach4: waited %0d cycles mismatches %0d required duty 4 with 0 mismatches", k, pre_mism);
        end
        target_duty = 3'd1; start = 1'b1;
        run_obs(700);
        n_tests++;
        if (obs_mism != 0 || obs_seen.size() != 3 || obs_seen[0] != 3'd4 || obs_seen[1] != 3'd2 || obs_seen[2] != 3'd1) begin
            n_fail++; $display("FAIL reverse_steps: got %s (mismatches %0d) required 4 2 1", seen_str(), obs_mism);
        end
        target_duty = 3'd7; stop = 1'b1; start = 1'b1;
        run_obs(500);
        n_tests++;
        if (obs_mism != 0 || duty_act !== 3'd0 || busy !== 1'b0 || obs_dones != 1) begin
            n_fail++; $display("FAIL stop_priority: duty_act %0d busy %b dones %0d mismatches %0d required 0 0 1 0",
                               duty_act, busy, obs_dones, obs_mism);
        end
    endtask

    task automatic test_async_reset();
        target_duty = 3'd7; step_size = 3'd1; start = 1'b1;
        run_obs(300);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({pwm_out, duty_act, period_tick, busy, done} !== 7'd0) begin
            n_fail++; $display("FAIL async_reset: got %b required 0000000", dut_vec);
        end
        @(negedge clk);
        rst = 1'b0;
        run_obs(100);
        n_tests++;
        if (obs_mism != 0 || obs_dones != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: mismatches %0d dones %0d busy %b required 0 0 0", obs_mism, obs_dones, busy);
        end
        target_duty = 3'd3; step_size = 3'd0; start = 1'b1;
        run_obs(600);
        n_tests++;
        if (obs_mism != 0 || obs_dones != 1 || obs_seen.size() != 3 || obs_seen[2] != 3'd3) begin
            n_fail++; $display("FAIL restart_ramp: got %s dones %0d mismatches %0d required 1 2 3, 1, 0",
                               seen_str(), obs_dones, obs_mism);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int r;
            r = $urandom_range(0, 9);
            target_duty = 3'($urandom_range(0, 7));
            step_size   = 3'($urandom_range(0, 7));
            start = (r < 5 || r == 8) ? 1'b1 : 1'b0;
            stop  = (r >= 5) ? 1'b1 : 1'b0;
            run_obs($urandom_range(20, 450));
            n_tests++;
            if (obs_mism != 0) begin
                n_fail++; $display("FAIL random_seg%0d: %0d cycles differ, first got %b required %b", i, obs_mism, obs_got, obs_exp);
            end
        end
    endtask

`ifdef PWM_BREATHE_EN
    task automatic test_breathe();
        stop = 1'b1;
        run_obs(600);
        target_duty = 3'd4; step_size = 3'd4; start = 1'b1;
        run_obs(1600);
        n_tests++;
        if (obs_mism != 0 || obs_seen.size() < 4 || obs_seen[0] != 3'd4 || obs_seen[1] != 3'd0 ||
            obs_seen[2] != 3'd4 || obs_seen[3] != 3'd0 || obs_dones < 4) begin
            n_fail++; $display("FAIL breathe_cycle: got %s dones %0d mismatches %0d required 4 0 4 0 with >=4 dones",
                               seen_str(), obs_dones, obs_mism);
        end
        stop = 1'b1;
        run_obs(800);
        n_tests++;
        if (obs_mism != 0 || busy !== 1'b0 || duty_act !== '0) begin
            n_fail++; $display("FAIL breathe_stop: busy %b duty_act %0d mismatches %0d required 0 0 0", busy, duty_act, obs_mism);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef PWM_BREATHE_EN
        test_breathe();
`else
        test_ramp_up();
        test_clamp_drain();
        test_reverse();
`endif
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Sequencer for the team's free-running counter/compare PWM LED driver.
- Owns the period counter and the compare stage.
- Moves the active duty cycle toward a programmed target in fixed steps, one step every STEP_PERIODS PWM periods, so LEDs fade instead of jumping.
- Duty changes take effect only at period boundaries, so no pulse is ever truncated or glitched.

Parameters:
- CBITS, 20: period counter width; PWM period = 2^CBITS clk cycles.
- DBITS, 8: duty resolution; duty is compared against cnt[CBITS-1 -: DBITS]. Must satisfy DBITS <= CBITS.
- STEP_PERIODS, 4: PWM periods between consecutive duty steps. Must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  1-cycle pulse; latch target_duty/step_size and ramp toward target
- stop  in  1  1-cycle pulse; ramp down to 0, then idle
- target_duty  in  DBITS  requested duty (high time = target_duty * 2^(CBITS-DBITS) cycles)
- step_size  in  DBITS  duty increment per step; 0 treated as 1
- pwm_out  out  1  PWM output, registered
- duty_act  out  DBITS  duty currently applied to the compare
- period_tick  out  1  high in the cycle where cnt == 2^CBITS-1
- busy  out  1  high in RAMP or DRAIN
- done  out  1  1-cycle pulse when a ramp or drain completes

Behaviour:
- Reset values: all outputs 0; cnt=0, duty_cur=0, duty_act=0, goal=0, step_cnt=0, state=IDLE. Reset mid-ramp aborts immediately with no done pulse.
- Counter: cnt increments every cycle and wraps 2^CBITS-1 -> 0. period_tick = (cnt == max), combinational from cnt.
- duty_act update: loaded from duty_cur on the edge where cnt wraps, and only then.
- PWM compare: pwm_out <= (cnt[CBITS-1 -: DBITS] < duty_act), one cycle of latency.
  - duty 0: pwm_out constantly low.
  - Max duty gives high time of (2^DBITS-1)/2^DBITS of the period.
- Step timer: step_cnt counts period_ticks while busy.
  - On the STEP_PERIODS-th tick, step_cnt clears and duty_cur moves one step toward goal.
  - Step arithmetic is done at DBITS+1 bits and clamped to goal: no overshoot, no wrap.
  - step_cnt clears whenever the FSM enters RAMP or DRAIN.
- FSM states: IDLE, RAMP, HOLD, DRAIN.
  - IDLE/HOLD + start: goal <= target_duty, step latched, go to RAMP.
  - RAMP + start: retarget. New goal and step are latched, and the ramp continues from duty_cur; direction may reverse.
  - RAMP with duty_cur == goal: go to HOLD and pulse done. This covers start with target == duty_cur, which reaches HOLD one cycle after entering RAMP.
  - Any state except IDLE + stop: goal <= 0, go to DRAIN. In HOLD/DRAIN the previously latched step is kept.
  - DRAIN with duty_cur == 0: go to IDLE and pulse done.
  - IDLE + stop: ignored.
- Priority: stop beats start in the same cycle.
- Input sampling: target_duty and step_size are sampled only on an accepted start.
- Lag at end of ramp: duty_act reaches the final value at the next wrap after duty_cur does, so pwm_out lags done by up to one period.

Optional Feature:
- Macro: PWM_BREATHE_EN.
- Defined: HOLD with goal != 0 does not stay. After STEP_PERIODS periods it enters DRAIN automatically. DRAIN reaching 0 re-enters RAMP toward the latched target, and this repeats until stop or rst. done pulses at every endpoint. stop during breathing latches a drain-to-idle flag, so the next time duty_cur reaches 0 the FSM goes to IDLE.
- Undefined: HOLD persists indefinitely. The breathe logic and flag are absent.

Decomposition:
- Shared package pwm_pkg:
  - state enum (IDLE, RAMP, HOLD, DRAIN)
  - default CBITS/DBITS constants
  - function sat_step(cur, goal, step) returning the clamped next duty
- One sub-module, pwm_core: cnt, period_tick, duty_act latch at wrap, and registered compare.
- pwm_ramp_ctrl instantiates pwm_core and holds the FSM and step timer.

Test Plan (bench params CBITS=6, DBITS=3, STEP_PERIODS=2; period 64 cycles, 8 cycles per duty LSB):
- Reset then idle 200 cycles -> pwm_out=0, duty_act=0, busy=0, done never asserted.
- start, target=6, step=2 -> duty_cur 2,4,6 at every 2nd period_tick. done pulses once at 6. duty_act changes only on the cycle after cnt==63. Steady state shows pwm_out high exactly 48 of 64 cycles.
- start, target=7, step=3 from 0 -> steps 3,6,7 (clamped, no overshoot). In HOLD, stop with step=3 latched -> steps 4,1,0, then IDLE and done.
- Mid-RAMP at duty 4: start with target=1 -> direction reverses, reaching 1 with no intermediate overshoot. stop and start in the same cycle -> DRAIN taken.
- rst asserted mid-ramp -> all outputs 0 within the same cycle (asynchronous). After release, operation restarts from IDLE.
- PWM_BREATHE_EN defined, start target=4 step=4 -> duty cycles 4,0,4,0 with done at each endpoint. stop -> IDLE after the next 0.
